// File: rtl/fft_bitrev_loader.sv
// Input reorder buffer for the radix-2 FFT: loads one frame in natural order at
// bit-reversed addresses, then issues N/2 registered (A, B) operand pairs.
module fft_bitrev_loader #(
    parameter int                 LOG2_N      = 3,
    parameter int                 WORD_SZ     = 32,
    parameter logic [WORD_SZ-1:0] TWIDDLE_ONE = 32'h0040_0000
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic [WORD_SZ-1:0]   i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [WORD_SZ-1:0]   o_A,
    output logic [WORD_SZ-1:0]   o_B,
    output logic [WORD_SZ-1:0]   o_twiddleA,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [LOG2_N-2:0]    o_pair_idx,
    output logic                 o_frame_done
);

    localparam int                N       = 1 << LOG2_N;
    localparam int                PAIR_W  = LOG2_N - 1;
    localparam logic [LOG2_N-1:0] LAST_WR = '1;
    localparam logic [PAIR_W-1:0] LAST_K  = '1;

    typedef enum logic [1:0] {
        S_FILL,
        S_PRIME,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WORD_SZ-1:0]  r_mem [N];
    logic [LOG2_N-1:0]   r_wr_cnt;
    logic [WORD_SZ-1:0]  r_A;
    logic [WORD_SZ-1:0]  r_B;
    logic [PAIR_W-1:0]   r_pair_idx;
    logic                r_valid;
    logic                r_frame_done;
    logic                w_accept;
    logic                w_load_en;
    logic [PAIR_W-1:0]   w_load_k;
    logic                w_finish;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = v[LOG2_N-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        w_load_en    = 1'b0;
        w_load_k     = '0;
        w_finish     = 1'b0;
        case (r_state)
            S_FILL: begin
                o_ready = 1'b1;
                if (i_valid && (r_wr_cnt == LAST_WR)) begin
                    w_next_state = S_PRIME;
                end
            end
            S_PRIME: begin
                w_load_en    = 1'b1;
                w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_valid && i_ready) begin
                    if (r_pair_idx == LAST_K) begin
                        w_finish     = 1'b1;
                        w_next_state = S_FILL;
                    end else begin
                        w_load_en = 1'b1;
                        w_load_k  = r_pair_idx + PAIR_W'(1);
                    end
                end
            end
            default: w_next_state = S_FILL;
        endcase
    end

    assign w_accept = o_ready && i_valid;

    // Sample storage is never reset; a partial frame is simply overwritten.
    always_ff @(posedge i_CLK) begin
        if (w_accept) begin
            r_mem[bitrev(r_wr_cnt)] <= i_data;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_wr_cnt     <= '0;
            r_A          <= '0;
            r_B          <= '0;
            r_pair_idx   <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_finish;
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + LOG2_N'(1);
            end
            // Pair k sits at adjacent addresses 2k and 2k+1 after reordering.
            if (w_load_en) begin
                r_A        <= r_mem[{w_load_k, 1'b0}];
                r_B        <= r_mem[{w_load_k, 1'b1}];
                r_pair_idx <= w_load_k;
                r_valid    <= 1'b1;
            end else if (w_finish) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_A          = r_A;
    assign o_B          = r_B;
    assign o_pair_idx   = r_pair_idx;
    assign o_valid      = r_valid;
    assign o_frame_done = r_frame_done;
    assign o_twiddleA   = TWIDDLE_ONE;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench for fft_bitrev_loader (N = 8): ordering, latency, stalls,
// back-pressure on the input side and asynchronous reset mid-fill / mid-drain.
module tb_fft_bitrev_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_A;
    logic [31:0] o_B;
    logic [31:0] o_twiddleA;
    logic        o_valid;
    logic        i_ready;
    logic [1:0]  o_pair_idx;
    logic        o_frame_done;

    int checks   = 0;
    int failures = 0;

    // Natural-order sample index feeding A and B of pair k, for N = 8:
    // pair k -> (x[SRC[2k]], x[SRC[2k+1]]).
    int SRC [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_loader dut (
        .i_CLK        (clk),
        .i_RST        (rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_A          (o_A),
        .o_B          (o_B),
        .o_twiddleA   (o_twiddleA),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pair_idx   (o_pair_idx),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] sample(input logic [15:0] base, input int n);
        return {base + 16'(n), 16'h0000};
    endfunction

    // Drives n samples of a frame; for a full frame also checks PRIME timing.
    task automatic load_frame(input logic [15:0] base, input int n, input bit toggle, input bit hold);
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                i_valid = 1'b0;
                @(negedge clk);
            end
            i_data  = sample(base, i);
            i_valid = 1'b1;
            check("fill_ready", 64'(o_ready), 64'd1);
            check("fill_valid", 64'(o_valid), 64'd0);
            @(negedge clk);
            if (i == 0) check("done_one_cycle", 64'(o_frame_done), 64'd0);
        end
        i_valid = hold;
        i_data  = hold ? 32'hDEAD_BEEF : 32'h0;
        if (n == 8) begin
            check("prime_valid", 64'(o_valid), 64'd0);
            check("prime_ready", 64'(o_ready), 64'd0);
            @(negedge clk);
        end
    endtask

    task automatic expect_pair(input logic [15:0] base, input int k, input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_A"}, 64'(o_A), 64'(sample(base, SRC[2*k])));
        check({tag, "_B"}, 64'(o_B), 64'(sample(base, SRC[2*k+1])));
        check({tag, "_idx"}, 64'(o_pair_idx), 64'(k));
        check({tag, "_tw"}, 64'(o_twiddleA), 64'h0040_0000);
    endtask

    task automatic drain_frame(input logic [15:0] base, input int stall_k, input int abort_k);
        for (int k = 0; k < 4; k++) begin
            expect_pair(base, k, "pair");
            check("drain_ready", 64'(o_ready), 64'd0);
            check("drain_done", 64'(o_frame_done), 64'd0);
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", 64'(o_valid), 64'd0);
                check("abort_A", 64'(o_A), 64'd0);
                check("abort_idx", 64'(o_pair_idx), 64'd0);
                @(negedge clk);
                rst_n   = 1'b1;
                i_valid = 1'b0;
                check("abort_ready", 64'(o_ready), 64'd1);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("abort_no_done", 64'(o_frame_done), 64'd0);
                    check("abort_no_valid", 64'(o_valid), 64'd0);
                end
                return;
            end
            if (k == stall_k) begin
                i_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    expect_pair(base, k, "stall");
                end
                i_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("end_done", 64'(o_frame_done), 64'd1);
        check("end_valid", 64'(o_valid), 64'd0);
        check("end_ready", 64'(o_ready), 64'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_data  = 32'h0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_A", 64'(o_A), 64'd0);
        check("rst_B", 64'(o_B), 64'd0);
        check("rst_idx", 64'(o_pair_idx), 64'd0);
        check("rst_done", 64'(o_frame_done), 64'd0);
        check("rst_tw", 64'(o_twiddleA), 64'h0040_0000);
        check("rst_ready", 64'(o_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame 0x0001..0x0008, back-to-back.
        load_frame(16'h0001, 8, 1'b0, 1'b0);
        drain_frame(16'h0001, -1, -1);

        // i_valid toggled every other cycle.
        load_frame(16'h0011, 8, 1'b1, 1'b0);
        drain_frame(16'h0011, -1, -1);

        // Downstream stalls 3 cycles on pair 2.
        load_frame(16'h0021, 8, 1'b0, 1'b0);
        drain_frame(16'h0021, 2, -1);

        // Upstream holds i_valid through PRIME/DRAIN; next frame follows at once.
        load_frame(16'h0031, 8, 1'b0, 1'b1);
        drain_frame(16'h0031, -1, -1);
        load_frame(16'h0041, 8, 1'b0, 1'b0);
        drain_frame(16'h0041, -1, -1);

        // Reset after 5 samples discards the partial frame.
        load_frame(16'h0091, 5, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midfill_valid", 64'(o_valid), 64'd0);
        check("midfill_A", 64'(o_A), 64'd0);
        check("midfill_B", 64'(o_B), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        load_frame(16'h0051, 8, 1'b0, 1'b0);
        drain_frame(16'h0051, -1, -1);

        // Reset while pair 1 is outstanding, then a clean frame.
        load_frame(16'h0061, 8, 1'b0, 1'b0);
        drain_frame(16'h0061, -1, 1);
        load_frame(16'h0071, 8, 1'b0, 1'b0);
        drain_frame(16'h0071, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_loader.md
# fft_bitrev_loader

Input reorder buffer that sits directly upstream of the radix-2 butterfly stage in the FFT datapath. It accepts one frame of N complex samples in natural order over a valid/ready stream, stores each at its bit-reversed address, then presents the frame as N/2 registered (A, B) operand pairs with the stage-1 twiddle, ready to drive the butterfly's A, B and twiddle inputs. A frame is fully loaded before any pair is issued; there is no overlap between frames.

## Interface
Parameters:
- LOG2_N, 3, log2 of frame length N (N = 8 by default; legal range 2..10)
- WORD_SZ, 32, complex word width; real in [WORD_SZ-1:WORD_SZ/2], imag in [WORD_SZ/2-1:0], signed Q9.6 per half
- TWIDDLE_ONE, 32'h0040_0000, stage-1 twiddle W2^0 = 1.0 + j0 in Q9.6

Ports:
- i_CLK  input  1  clock; all state changes on rising edge
- i_RST  input  1  reset; one clock; reset is asynchronous and active-low
- i_data  input  WORD_SZ  input sample, natural order
- i_valid  input  1  i_data valid
- o_ready  output  1  block accepts a sample this cycle
- o_A  output  WORD_SZ  butterfly operand A (registered)
- o_B  output  WORD_SZ  butterfly operand B (registered)
- o_twiddleA  output  WORD_SZ  twiddle for the pair; constant TWIDDLE_ONE
- o_valid  output  1  o_A/o_B hold a valid pair
- i_ready  input  1  downstream takes the pair this cycle
- o_pair_idx  output  LOG2_N-1  index k of the pair on o_A/o_B
- o_frame_done  output  1  one-cycle pulse on acceptance of the last pair of a frame

## Operation
- Storage: N x WORD_SZ register array; contents not cleared by reset.
- State machine FILL -> PRIME -> DRAIN -> FILL.
- FILL: o_ready = 1, o_valid = 0. On i_valid && o_ready, write mem[bitrev(wr_cnt)] = i_data, wr_cnt++. Accepting sample wr_cnt = N-1 -> PRIME, wr_cnt wraps to 0.
- PRIME: o_ready = 0. Load o_A = mem[0], o_B = mem[1], o_pair_idx = 0, set o_valid. -> DRAIN.
- DRAIN: o_ready = 0. Pair k: o_A = mem[2k], o_B = mem[2k+1] (i.e. x[bitrev(2k)], x[bitrev(2k+1)]). On o_valid && i_ready: if k < N/2-1, load pair k+1 the same edge (o_valid stays 1); if k = N/2-1, clear o_valid, pulse o_frame_done, -> FILL.
- i_ready low: o_A, o_B, o_pair_idx, o_valid hold unchanged.
- bitrev(i) reverses the LOG2_N bits of i. No arithmetic is done on sample data; words pass through bit-exact.
- i_valid in PRIME/DRAIN is ignored (o_ready = 0); upstream must hold the sample.

## Timing
- Reset (i_RST = 0, any time, mid-fill or mid-drain): state FILL, wr_cnt = 0, rd_cnt = 0, o_ready = 1 after release (combinational from state), o_valid = 0, o_A = o_B = 0, o_pair_idx = 0, o_frame_done = 0. Partial frame discarded.
- o_twiddleA is constant TWIDDLE_ONE, including in reset.
- Last sample accepted at edge t: PRIME during cycle t..t+1, o_valid = 1 after edge t+1 (first pair 2 edges after last sample).
- Throughput: one pair per cycle with i_ready held high; frame period = N + 1 + N/2 cycles minimum.
- After final pair handshake at edge u: o_ready = 1 from edge u, next sample accepted at edge u+1 earliest.
- o_frame_done high exactly the cycle following the final handshake edge.

## Test plan
- Reset, then N = 8 samples 0x0001_0000..0x0008_0000 with i_valid high, i_ready high -> pairs (x0,x4),(x2,x6),(x1,x5),(x3,x7) i.e. o_A/o_B = 0x0001/0x0005, 0x0003/0x0007, 0x0002/0x0006, 0x0004/0x0008 upper halves, o_pair_idx 0..3, o_frame_done once, o_twiddleA = 0x0040_0000 throughout.
- Same frame with i_valid toggled every other cycle -> identical pair sequence; o_valid rises 2 cycles after 8th acceptance.
- i_ready low for 3 cycles on pair 2 -> o_A/o_B/o_pair_idx stable for those cycles, no skipped or duplicated pair.
- Upstream holds i_valid high across drain -> o_ready = 0 during PRIME/DRAIN, no writes; next frame's first sample accepted the cycle after o_frame_done.
- Assert i_RST after 5 samples, release, send full 8-sample frame -> output matches the new frame only; o_valid = 0 and outputs 0 during reset.
- Assert i_RST mid-drain (pair 1 outstanding) -> o_valid drops immediately (async), no o_frame_done, o_ready = 1 after release.
